step_sched: RTL and testbench

STEP_SCHED -- requirements
Module: step_sched

---
 rtl/step_sched.sv | 154 +++++++++++++++
 tb/tb_step_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_sched.sv
// Sequencer for block Gaussian elimination: one pivot op (functionA) per phase, then apply ops.
// Latency: step_start one cycle after go; done two cycles after the last step_done.
// Backpressure: one step op in flight; waits on step_done, bounded by a TIMEOUT watchdog.
module step_sched #(
  parameter int N       = 4,
  parameter int L       = 8,
  parameter int K       = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 go,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 fail,
  output logic                                 step_start,
  output logic [$clog2(K/N+1)-1:0]             step_col_block,
  output logic                                 step_functionA,
  output logic                                 step_last_phase,
  output logic [$clog2(L*(K/N)+2*N+1)-1:0]     step_first_pass_rows,
  input  logic                                 step_done,
  input  logic                                 step_fail
);

  localparam int NB  = K / N;
  localparam int P   = (L + N - 1) / N;
  localparam int CBW = $clog2(NB + 1);
  localparam int FPW = $clog2(L * NB + 2 * N + 1);
  localparam int WDW = $clog2(TIMEOUT + 1);

  // Phase index never exceeds the block count (L <= K), so p shares the block width.
  localparam logic [CBW-1:0] NB_M1   = CBW'(NB - 1);
  localparam logic [CBW-1:0] P_M1    = CBW'(P - 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    NEXT  = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t         state;
  logic [CBW-1:0] p_q;
  logic [CBW-1:0] c_q;
  logic [WDW-1:0] wd_q;

  logic [CBW-1:0] nxt_p;
  logic [CBW-1:0] nxt_c;
  logic           have_next;
  logic [FPW-1:0] nxt_fpr;

  // Pick the next (phase, block) to issue: a fresh run starts at (0,0); otherwise walk
  // the remaining blocks of this phase, then jump to the next phase's pivot block.
  always_comb begin
    nxt_p     = p_q;
    nxt_c     = c_q;
    have_next = 1'b1;
    if (state == IDLE) begin
      nxt_p = '0;
      nxt_c = '0;
    end else if (c_q < NB_M1) begin
      nxt_c = c_q + CBW'(1);
    end else if (p_q < P_M1) begin
      nxt_p = p_q + CBW'(1);
      nxt_c = p_q + CBW'(1);
    end else begin
      have_next = 1'b0;
    end
    nxt_fpr = FPW'(nxt_c) * FPW'(L) + FPW'(N);
  end

  // Control FSM; every output is registered and the op descriptor is loaded on entry to ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      fail                 <= 1'b0;
      step_start           <= 1'b0;
      step_col_block       <= '0;
      step_functionA       <= 1'b0;
      step_last_phase      <= 1'b0;
      step_first_pass_rows <= '0;
      p_q                  <= '0;
      c_q                  <= '0;
      wd_q                 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            busy                 <= 1'b1;
            fail                 <= 1'b0;
            p_q                  <= nxt_p;
            c_q                  <= nxt_c;
            step_col_block       <= nxt_c;
            step_functionA       <= (nxt_c == nxt_p);
            step_last_phase      <= (nxt_p == P_M1);
            step_first_pass_rows <= nxt_fpr;
            step_start           <= 1'b1;
            state                <= ISSUE;
          end
        end
        ISSUE: begin
          step_start <= 1'b0;
          wd_q       <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          // A completion on the last allowed cycle wins over the watchdog.
          if (step_done) begin
            if (step_functionA && step_fail) begin
              fail  <= 1'b1;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              state <= NEXT;
            end
          end else if (wd_q == WD_LAST) begin
            wd_q  <= wd_q + WDW'(1);
            fail  <= 1'b1;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            wd_q <= wd_q + WDW'(1);
          end
        end
        NEXT: begin
          if (have_next) begin
            p_q                  <= nxt_p;
            c_q                  <= nxt_c;
            step_col_block       <= nxt_c;
            step_functionA       <= (nxt_c == nxt_p);
            step_last_phase      <= (nxt_p == P_M1);
            step_first_pass_rows <= nxt_fpr;
            step_start           <= 1'b1;
            state                <= ISSUE;
          end else begin
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step_sched.sv
// Randomized scoreboard bench for step_sched: expected ops/results are queued per run.
// A responder models the step stage; a monitor checks every step_start and done.
// Run length is bounded by a cycle budget per run.
module tb_step_sched;

  localparam int N   = 4;
  localparam int L   = 8;
  localparam int K   = 16;
  localparam int TO  = 40;
  localparam int NB  = K / N;
  localparam int P   = (L + N - 1) / N;
  localparam int CBW = $clog2(NB + 1);
  localparam int FPW = $clog2(L * NB + 2 * N + 1);
  localparam int MAXOPS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go = 1'b0;
  logic step_done = 1'b0;
  logic step_fail = 1'b0;
  logic busy, done, fail, step_start, step_functionA, step_last_phase;
  logic [CBW-1:0] step_col_block;
  logic [FPW-1:0] step_first_pass_rows;

  step_sched #(.N(N), .L(L), .K(K), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done), .fail(fail),
    .step_start(step_start), .step_col_block(step_col_block),
    .step_functionA(step_functionA), .step_last_phase(step_last_phase),
    .step_first_pass_rows(step_first_pass_rows),
    .step_done(step_done), .step_fail(step_fail)
  );

  always #5 clk = ~clk;

  typedef struct { int cb; int a; int last; int fpr; } op_t;
  typedef struct { int fl; int lat; } res_t;

  op_t  exp_ops[$];
  res_t exp_res[$];
  op_t  eo;
  res_t er;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_start = 0;
  int n_starts = 0;
  int n_done = 0;
  int dly[MAXOPS];
  bit fl[MAXOPS];
  int resp_idx = 0;
  int gen = 0;
  int run_fail_exp = 0;
  int r_g, r_idx, r_d;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: phases p, each a pivot op on block p then apply ops on p+1..NB-1.
  // dly[i]==0 or > TO means the step stage never answers op i.
  task automatic build_expect();
    int i = 0;
    bit stop = 0;
    res_t r;
    r.fl = 0;
    r.lat = 0;
    for (int p = 0; p < P; p++) begin
      for (int c = p; c < NB; c++) begin
        if (!stop) begin
          op_t o;
          o.cb = c; o.a = (c == p) ? 1 : 0; o.last = (p == P - 1) ? 1 : 0; o.fpr = c * L + N;
          exp_ops.push_back(o);
          if (dly[i] == 0 || dly[i] > TO) begin
            stop = 1; r.fl = 1; r.lat = TO + 1;
          end else if (c == p && fl[i]) begin
            stop = 1; r.fl = 1; r.lat = dly[i] + 1;
          end else begin
            r.lat = dly[i] + 2;
          end
          i++;
        end
      end
    end
    exp_res.push_back(r);
    run_fail_exp = r.fl;
  endtask

  // Step-stage responder: answers op i dly[i] cycles after its start pulse.
  initial forever begin
    @(negedge clk);
    if (!rst && step_start) begin
      r_g = gen;
      r_idx = resp_idx;
      resp_idx++;
      r_d = (r_idx < MAXOPS) ? dly[r_idx] : 0;
      if (r_d > 0 && r_d <= TO) begin
        repeat (r_d) @(negedge clk);
        if (gen == r_g && !rst) begin
          step_done = 1'b1;
          step_fail = fl[r_idx];
          @(negedge clk);
          step_done = 1'b0;
          step_fail = 1'b0;
        end
      end
    end
  end

  // Monitor: pops and compares whenever the DUT presents a start or done.
  always @(negedge clk) begin
    if (!rst) begin
      if (step_start) begin
        n_starts++;
        last_start = cyc;
        n_vec++;
        if (exp_ops.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_start: got cb=%0d A=%0d, required no start",
                   int'(step_col_block), int'(step_functionA));
        end else begin
          eo = exp_ops.pop_front();
          if (int'(step_col_block) != eo.cb || int'(step_functionA) != eo.a ||
              int'(step_last_phase) != eo.last || int'(step_first_pass_rows) != eo.fpr ||
              busy != 1'b1) begin
            n_err++;
            $display("FAIL op: got cb=%0d A=%0d last=%0d fpr=%0d busy=%0d, required cb=%0d A=%0d last=%0d fpr=%0d busy=1",
                     int'(step_col_block), int'(step_functionA), int'(step_last_phase),
                     int'(step_first_pass_rows), int'(busy), eo.cb, eo.a, eo.last, eo.fpr);
          end
        end
      end
      if (done) begin
        n_done++;
        n_vec++;
        if (exp_res.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_done: got done fail=%0d, required no done", int'(fail));
        end else begin
          er = exp_res.pop_front();
          if (int'(fail) != er.fl || (cyc - last_start) != er.lat || exp_ops.size() != 0 ||
              busy != 1'b1) begin
            n_err++;
            $display("FAIL result: got fail=%0d lat=%0d left_ops=%0d busy=%0d, required fail=%0d lat=%0d left_ops=0 busy=1",
                     int'(fail), cyc - last_start, exp_ops.size(), int'(busy), er.fl, er.lat);
          end
        end
      end
    end
  end

  task automatic check_idle_zero(input string name);
    n_vec++;
    if (busy || done || fail || step_start || step_functionA || step_last_phase ||
        step_col_block != '0 || step_first_pass_rows != '0) begin
      n_err++;
      $display("FAIL %s: got busy=%0d done=%0d fail=%0d start=%0d A=%0d last=%0d cb=%0d fpr=%0d, required all 0",
               name, int'(busy), int'(done), int'(fail), int'(step_start), int'(step_functionA),
               int'(step_last_phase), int'(step_col_block), int'(step_first_pass_rows));
    end
  endtask

  task automatic start_run();
    build_expect();
    resp_idx = 0;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n_vec++;
    if (!(step_start && busy)) begin
      n_err++;
      $display("FAIL go_to_start: got start=%0d busy=%0d, required start=1 busy=1",
               int'(step_start), int'(busy));
    end
  endtask

  task automatic apply_run(input bit stray_go);
    int base;
    base = n_done;
    start_run();
    for (int i = 0; i < MAXOPS * (TO + 8) + 50 && n_done == base; i++) begin
      @(negedge clk);
      go = (stray_go && busy && $urandom_range(0, 5) == 0) ? 1'b1 : 1'b0;
    end
    go = 1'b0;
    n_vec++;
    if (n_done == base) begin
      n_err++;
      $display("FAIL run_timeout: got no done, required done within budget");
      exp_ops.delete();
      exp_res.delete();
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (int'(fail) != run_fail_exp || busy != 1'b0) begin
      n_err++;
      $display("FAIL fail_hold: got fail=%0d busy=%0d, required fail=%0d busy=0",
               int'(fail), int'(busy), run_fail_exp);
    end
  endtask

  task automatic set_all(input int d);
    for (int i = 0; i < MAXOPS; i++) begin
      dly[i] = d;
      fl[i] = 1'b0;
    end
  endtask

  initial begin
    int base;
    set_all(5);
    repeat (2) @(negedge clk);
    check_idle_zero("reset_state");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // clean run, responses 5 cycles after each start
    set_all(5);
    apply_run(1'b0);
    // failing pivot on the first op
    set_all(5); fl[0] = 1'b1;
    apply_run(1'b0);
    // step_fail on the apply op cb=2 is ignored
    set_all(5); fl[2] = 1'b1;
    apply_run(1'b0);
    // no response: watchdog
    set_all(5); dly[0] = 0;
    apply_run(1'b0);
    // response exactly on the last watchdog cycle still counts
    set_all(5); dly[0] = TO; dly[6] = TO;
    apply_run(1'b0);
    // one cycle later it is a timeout
    set_all(3); dly[4] = TO + 1;
    apply_run(1'b0);

    // reset while the third op is outstanding
    set_all(30);
    base = n_starts;
    start_run();
    for (int i = 0; i < 200 && n_starts < base + 3; i++) @(negedge clk);
    rst = 1'b1;
    gen++;
    @(negedge clk);
    check_idle_zero("reset_midrun");
    exp_ops.delete();
    exp_res.delete();
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check_idle_zero("after_reset_no_done");
    set_all(2);
    apply_run(1'b1);

    // randomized runs with go pulses while busy
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < MAXOPS; i++) begin
        dly[i] = $urandom_range(1, 12);
        fl[i] = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 20) == 0) dly[i] = TO;
        if ($urandom_range(0, 40) == 0) dly[i] = 0;
      end
      apply_run(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
